line_bank_sched: RTL

LINE_BANK_SCHED -- requirements
Module: line_bank_sched

---
 rtl/line_bank_sched.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/line_bank_sched.sv
// Line-bank scheduler: rotates input/output line-RAM bank pointers for a vertical interpolator.
// Optional saturating drop counter on port errCnt when LBS_ERR_CNT_EN is defined.
module line_bank_sched #(
    parameter int unsigned BANK_W = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              frmStart,
    input  logic              wrLineDone,
    input  logic              wrLast,
    input  logic              rdAdvance,
    input  logic              rdFrameDone,
    output logic [BANK_W-1:0] wrBank,
    output logic [BANK_W-1:0] rdBankTop,
    output logic [BANK_W-1:0] rdBankBot,
    output logic              rdValid,
    output logic              inStall,
    output logic [BANK_W:0]   fillCnt,
    output logic [1:0]        state,
    output logic              ovfErr,
    output logic              udfErr
`ifdef LBS_ERR_CNT_EN
    ,
    output logic [7:0]        errCnt
`endif
);

    localparam int unsigned NBANK = 1 << BANK_W;
    localparam logic [BANK_W:0] FULL = NBANK[BANK_W:0];
    localparam logic [BANK_W:0] ONE  = (BANK_W+1)'(1);
    localparam logic [BANK_W:0] TWO  = (BANK_W+1)'(2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        RUN   = 2'd2,
        FLUSH = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [BANK_W-1:0] wr_bank_q, wr_bank_d;
    logic [BANK_W-1:0] top_q, top_d;
    logic [BANK_W-1:0] bot_q, bot_d;
    logic [BANK_W:0]   fill_q, fill_d;
    logic              valid_q, valid_d;
    logic              stall_q, stall_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              wr_open, wr_acc, wr_ovf, rd_acc, rd_udf;

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        top_d     = top_q;
        fill_d    = fill_q;
        ovf_d     = ovf_q;
        udf_d     = udf_q;

        // Acceptance is judged on pre-update occupancy so a simultaneous
        // write/read pair at full still lets the read through.
        wr_open = (state_q == FILL) || (state_q == RUN);
        wr_acc  = wrLineDone && wr_open && (fill_q != FULL);
        wr_ovf  = wrLineDone && wr_open && (fill_q == FULL);
        rd_acc  = rdAdvance && (((state_q == RUN) && (fill_q >= TWO)) ||
                                ((state_q == FLUSH) && (fill_q >= ONE)));
        rd_udf  = rdAdvance && !rd_acc;

        if (wr_acc) wr_bank_d = wr_bank_q + BANK_W'(1);
        if (rd_acc) top_d = top_q + BANK_W'(1);
        fill_d = fill_q + (BANK_W+1)'(wr_acc) - (BANK_W+1)'(rd_acc);
        if (wr_ovf) ovf_d = 1'b1;
        if (rd_udf) udf_d = 1'b1;

        unique case (state_q)
            FILL: begin
                if (wr_acc && wrLast)   state_d = FLUSH;
                else if (fill_d >= TWO) state_d = RUN;
            end
            RUN:     if (wr_acc && wrLast) state_d = FLUSH;
            FLUSH:   if (rdFrameDone)      state_d = IDLE;
            default: ;
        endcase

        if (frmStart) begin
            state_d   = FILL;
            wr_bank_d = '0;
            top_d     = '0;
            fill_d    = '0;
            ovf_d     = 1'b0;
            udf_d     = 1'b0;
        end

        // Last line of the frame is replicated as its own lower neighbour.
        bot_d   = ((state_d == FLUSH) && (fill_d == ONE)) ? top_d : top_d + BANK_W'(1);
        valid_d = ((state_d == RUN) && (fill_d >= TWO)) ||
                  ((state_d == FLUSH) && (fill_d >= ONE));
        stall_d = (fill_d == FULL);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            wr_bank_q <= '0;
            top_q     <= '0;
            bot_q     <= BANK_W'(1);
            fill_q    <= '0;
            valid_q   <= 1'b0;
            stall_q   <= 1'b0;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            top_q     <= top_d;
            bot_q     <= bot_d;
            fill_q    <= fill_d;
            valid_q   <= valid_d;
            stall_q   <= stall_d;
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
        end
    end

    assign state     = state_q;
    assign wrBank    = wr_bank_q;
    assign rdBankTop = top_q;
    assign rdBankBot = bot_q;
    assign fillCnt   = fill_q;
    assign rdValid   = valid_q;
    assign inStall   = stall_q;
    assign ovfErr    = ovf_q;
    assign udfErr    = udf_q;

`ifdef LBS_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;
    logic [8:0] err_sum;

    always_comb begin
        err_sum   = {1'b0, err_cnt_q} + 9'(wr_ovf) + 9'(rd_udf);
        err_cnt_d = (err_sum > 9'd255) ? 8'hFF : err_sum[7:0];
        if (frmStart) err_cnt_d = '0;
    end

    always_ff @(posedge clk) begin
        if (rst) err_cnt_q <= '0;
        else     err_cnt_q <= err_cnt_d;
    end

    assign errCnt = err_cnt_q;
`endif

endmodule
